// File: rtl/carry_bypass_adder_pipe_if.sv
// ---------------------------------------------------------------------------
// carry_bypass_adder_pipe_if
//
// Stream bundle for the pipelined carry-bypass adder/subtractor.
// The operand beat travels from the producer to the adder, and the result
// beat travels from the adder to the consumer.
//
//   in_valid   producer -> adder   operand beat valid
//   in_ready   adder -> producer   adder takes the beat this cycle
//   a, b       producer -> adder   operands (WIDTH bits)
//   cin        producer -> adder   carry-in (ignored when subtracting)
//   sub        producer -> adder   0: a+b+cin, 1: a-b
//   out_valid  adder -> consumer   result beat valid
//   out_ready  consumer -> adder   consumer takes the result
//   sum        adder -> consumer   result modulo 2^WIDTH
//   cout       adder -> consumer   carry out of the MSB (1 = no borrow on sub)
//   overflow   adder -> consumer   two's-complement overflow
//
// The master modport is the environment side (producer and consumer), and
// the slave modport is the adder itself.
// ---------------------------------------------------------------------------
interface carry_bypass_adder_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/carry_bypass_adder_pipe.sv
// ---------------------------------------------------------------------------
// carry_bypass_adder_pipe
//
// Pipelined carry-bypass adder/subtractor with a valid/ready stream interface.
// Operands are cut into BLOCK_LEN-bit carry-bypass blocks. Each pipeline stage
// resolves BLOCKS_PER_STAGE blocks and registers its carry for the next stage.
// Operand bits that have not been consumed yet ride down the pipeline with the
// carry, and finished sum bits ride down to the output, so every stage works
// on a different beat. One beat per cycle is sustained. Flow control is a
// single global stall.
//
// Ports
//   clk   single clock, rising edge
//   rst   synchronous, active-high reset
//   bus   slave side of carry_bypass_adder_pipe_if (operand and result streams)
//
// Parameters
//   WIDTH             operand and sum width (must match the interface WIDTH)
//   BLOCK_LEN         bits per carry-bypass block
//   BLOCKS_PER_STAGE  bypass blocks evaluated per pipeline stage
//   WIDTH must be a multiple of BLOCK_LEN*BLOCKS_PER_STAGE.
// ---------------------------------------------------------------------------
module carry_bypass_adder_pipe #(
  parameter int WIDTH            = 32,
  parameter int BLOCK_LEN        = 4,
  parameter int BLOCKS_PER_STAGE = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  carry_bypass_adder_pipe_if.slave    bus
);

  localparam int S          = BLOCK_LEN * BLOCKS_PER_STAGE;
  localparam int NUM_STAGES = WIDTH / S;
  localparam int LAST       = NUM_STAGES - 1;

  logic             advance;
  logic [WIDTH-1:0] bEff;
  logic             cinEff;

  // The whole pipeline moves when the output slot is empty or is being taken.
  // Otherwise every register holds. Bubbles are kept rather than squeezed out,
  // so one enable serves every stage.
  assign advance      = !g_stage[LAST].valid_q || bus.out_ready;
  assign bus.in_ready = advance;

  // Subtraction is done as a + ~b + 1, so the forced carry-in replaces cin.
  assign bEff   = bus.b ^ {WIDTH{bus.sub}};
  assign cinEff = bus.sub | bus.cin;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam int LO = k * S;
    localparam int HI = LO + S;

    logic              upValid;
    logic              upCarry;
    logic [WIDTH-1:LO] srcA;
    logic [WIDTH-1:LO] srcB;
    logic [S-1:0]      sliceA;
    logic [S-1:0]      sliceB;
    logic [S-1:0]      sliceSum;
    logic              sliceCout;

    logic              carry;
    logic              blkCin;
    logic              rc;
    logic              blkP;
    logic              pBit;

    logic              valid_q;
    logic              valid_d;
    logic              carry_q;
    logic              carry_d;
    logic [HI-1:0]     sum_q;
    logic [HI-1:0]     sum_d;

    // Stage 0 takes the operand beat straight from the bus. Later stages take
    // the unconsumed operand bits, the carry and the partial sum that the
    // previous stage registered.
    if (k == 0) begin : g_first
      assign upValid = bus.in_valid;
      assign upCarry = cinEff;
      assign srcA    = bus.a;
      assign srcB    = bEff;
      assign sum_d   = sliceSum;
    end else begin : g_next
      assign upValid = g_stage[k-1].valid_q;
      assign upCarry = g_stage[k-1].carry_q;
      assign srcA    = g_stage[k-1].g_rem.opA_q;
      assign srcB    = g_stage[k-1].g_rem.opB_q;
      assign sum_d   = {sliceSum, g_stage[k-1].sum_q};
    end

    assign sliceA  = srcA[HI-1:LO];
    assign sliceB  = srcB[HI-1:LO];
    assign valid_d = upValid;
    assign carry_d = sliceCout;

    // Carry-bypass evaluation of this stage's slice. Each block ripples
    // internally. If every bit in the block propagates, the block's incoming
    // carry is routed straight past it through the bypass mux, so the carry
    // through the stage only has to pass one ripple plus the chain of muxes.
    always_comb begin
      carry    = upCarry;
      blkCin   = 1'b0;
      rc       = 1'b0;
      blkP     = 1'b0;
      pBit     = 1'b0;
      sliceSum = '0;
      for (int blk = 0; blk < BLOCKS_PER_STAGE; blk++) begin
        blkCin = carry;
        rc     = carry;
        blkP   = 1'b1;
        for (int i = 0; i < BLOCK_LEN; i++) begin
          pBit = sliceA[blk*BLOCK_LEN+i] ^ sliceB[blk*BLOCK_LEN+i];
          sliceSum[blk*BLOCK_LEN+i] = pBit ^ rc;
          rc   = (sliceA[blk*BLOCK_LEN+i] & sliceB[blk*BLOCK_LEN+i]) | (pBit & rc);
          blkP = blkP & pBit;
        end
        carry = blkP ? blkCin : rc;
      end
      sliceCout = carry;
    end

    // Stage register: the valid bit always shifts with the pipeline. Carry and
    // sum only load for real beats, so the output holds the last result across
    // bubbles instead of picking up junk from idle inputs.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (advance) begin
        valid_q <= valid_d;
        if (valid_d) begin
          carry_q <= carry_d;
          sum_q   <= sum_d;
        end
      end
    end

    // Operand bits still to be added move down alongside the carry. The last
    // stage has nothing left to forward.
    if (HI < WIDTH) begin : g_rem
      logic [WIDTH-1:HI] opA_q;
      logic [WIDTH-1:HI] opB_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          opA_q <= '0;
          opB_q <= '0;
        end else if (advance && valid_d) begin
          opA_q <= srcA[WIDTH-1:HI];
          opB_q <= srcB[WIDTH-1:HI];
        end
      end
    end

    // Overflow needs the carry into the MSB. That carry is recovered from the
    // MSB sum bit and its two operand bits (c = s ^ a ^ b'), then XORed with
    // the carry out.
    if (k == LAST) begin : g_last
      logic msbCin;
      logic overflow_q;
      logic overflow_d;

      assign msbCin     = sliceSum[S-1] ^ sliceA[S-1] ^ sliceB[S-1];
      assign overflow_d = msbCin ^ sliceCout;

      always_ff @(posedge clk) begin
        if (rst) begin
          overflow_q <= 1'b0;
        end else if (advance && valid_d) begin
          overflow_q <= overflow_d;
        end
      end
    end
  end

  assign bus.out_valid = g_stage[LAST].valid_q;
  assign bus.sum       = g_stage[LAST].sum_q;
  assign bus.cout      = g_stage[LAST].carry_q;
  assign bus.overflow  = g_stage[LAST].g_last.overflow_q;

endmodule

// File: doc/carry_bypass_adder_pipe.md
# carry_bypass_adder_pipe

Parametrised, pipelined carry-bypass adder/subtractor with a valid/ready stream interface. Operands are split into carry-bypass blocks, and the blocks are grouped into pipeline stages with the inter-stage carry registered. Sustains one operation per cycle, supports back-pressure, and adds a subtract mode and a signed-overflow flag. It replaces the fixed-width combinational carry-bypass adder in datapaths that need a higher clock rate.

## Interface
- WIDTH, 32, operand and sum width in bits.
- BLOCK_LEN, 4, bits per carry-bypass block.
- BLOCKS_PER_STAGE, 2, bypass blocks evaluated combinationally per pipeline stage.
- Constraint: WIDTH % (BLOCK_LEN*BLOCKS_PER_STAGE) == 0. Define NUM_STAGES = WIDTH/(BLOCK_LEN*BLOCKS_PER_STAGE).
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in. Ignored when sub=1.
- sub  in  1  0: A+B+cin. 1: A-B, computed as A+~B+1.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1. For subtraction, 1 means no borrow.
- overflow  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- Block function: with p_i = a_i^b'_i, P = AND of p_i over the block.
  - Block carry-out = P ? block_cin : ripple carry-out of the block.
  - The bypass mux is explicit per block.
- b' = sub ? ~b : b. Effective carry-in = sub ? 1 : cin.
- Stage k (0..NUM_STAGES-1) computes sum bits [(k+1)*S-1 : k*S], where S = BLOCK_LEN*BLOCKS_PER_STAGE.
  - Stage 0 uses the effective carry-in. Stage k>0 uses stage k-1's registered carry.
- Skewing: unprocessed operand slices travel down the pipeline alongside the registered carry. Finished sum slices also travel down to the output.
- Each stage holds a valid bit, carry register, partial sum, and remaining operand bits.
- Last stage registers sum, cout and overflow. Overflow needs the carry into the MSB, so the last stage retains it.
- Flow control is a global stall: advance = !out_valid | out_ready; in_ready = advance.
  - When advance=1, every stage shifts forward one position. Stage-0 valid loads in_valid & in_ready.
  - When advance=0, all registers hold.
  - Bubbles are not compressed.
- Beats leave strictly in acceptance order. No beat is dropped or duplicated.
- Reset clears all valid bits, carry registers and data registers to 0. Outputs after reset: out_valid=0, sum=0, cout=0, overflow=0, in_ready=1.

## Timing
- Latency is NUM_STAGES cycles. A beat accepted at edge t (in_valid & in_ready) has out_valid=1 after edge t+NUM_STAGES, provided there is no stall.
- Throughput is 1 beat/cycle while out_ready=1.
- Stall:
  - out_valid=1 & out_ready=0: in_ready drops combinationally in the same cycle.
  - sum, cout and overflow hold stable until the handshake completes.
- Simultaneous output handshake and input acceptance in one cycle is legal and required for full throughput.
- in_valid=0 with in_ready=1 inserts a bubble, which emerges later as an out_valid=0 cycle.
- Reset mid-operation:
  - All in-flight beats are discarded at the reset edge. out_valid=0 from the next cycle.
  - Inputs presented during rst=1 are not accepted.
- Combinational path per stage is BLOCKS_PER_STAGE bypass muxes plus one block ripple. There is no combinational path from a/b to sum.

## Test plan
All scenarios use WIDTH=16, BLOCK_LEN=4, BLOCKS_PER_STAGE=2, so NUM_STAGES=2.
- Reset: hold rst=1 for 2 cycles with in_valid=1 and random data -> out_valid=0, sum=0, cout=0, overflow=0 throughout. After release, in_ready=1.
- Full propagate (bypass path): a=16'hFFFF, b=16'h0000, cin=1, sub=0 -> two cycles later out_valid=1, sum=16'h0000, cout=1, overflow=0.
- Subtract with borrow: a=16'h0005, b=16'h0007, sub=1, cin=0 -> sum=16'hFFFE, cout=0, overflow=0. Also a=16'h0007, b=16'h0005, sub=1 -> sum=16'h0002, cout=1.
- Signed overflow: a=16'h7FFF, b=16'h0001, sub=0, cin=0 -> sum=16'h8000, cout=0, overflow=1. Also a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, cout=1, overflow=1.
- Back-pressure: stream 6 back-to-back beats (a=i, b=16'h0100, i=1..6); hold out_ready=0 for 3 cycles after the first result -> in_ready=0 during the stall, and results 16'h0101..16'h0106 appear exactly once, in order, at 1 beat/cycle once out_ready returns.
- Reset mid-stream: accept 2 beats, assert rst for 1 cycle before either emerges -> neither beat appears, and a beat accepted after reset emerges with the correct sum 2 cycles later.
